cursor_ctrl_rpt: RTL and testbench
==================================

Name: cursor_ctrl_rpt

Overview:
Parametrised successor to the chess top-level's inline cursor logic. Decodes the 11-bit keyboard event bus into a board cursor position plus select/cancel strobes. Adds:
- configurable board size;
- wrap or clamp edge mode;
- atomic diagonal moves;
- typematic auto-repeat while a move key is held.

Sits between the keyboard block and the game/play logic on the system clock domain.

Parameters:
BOARD_W, 8, number of columns (2..16)
BOARD_H, 8, number of rows (2..16)
COORD_W, 4, width of cursor_x/cursor_y; must satisfy 2^COORD_W >= max(BOARD_W,BOARD_H)
WRAP, 0, 0 = clamp at edges, 1 = wrap around edges
INIT_X, 0, cursor_x after reset
INIT_Y, 0, cursor_y after reset
REPEAT_DELAY, 50_000_000, cycles a move key must be held before the first repeat (0 disables repeat)
REPEAT_PERIOD, 10_000_000, cycles between subsequent repeats (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
rstn  in  1  reset, synchronous, active-low
key_event  in  11  [10] valid, [9] extended, [8] break, [7:0] ASCII code
cursor_x  out  COORD_W  current column, 0..BOARD_W-1
cursor_y  out  COORD_W  current row, 0..BOARD_H-1
move_pulse  out  1  one-cycle strobe: cursor changed (press or repeat)
blocked_pulse  out  1  one-cycle strobe: clamp mode rejected a move
select_pulse  out  1  one-cycle strobe: space (0x20) pressed
cancel_pulse  out  1  one-cycle strobe: Esc (0x1B) pressed

Behaviour:
Reset (rstn=0 at a clk edge):
- cursor_x=INIT_X, cursor_y=INIT_Y.
- All pulses 0, FSM=IDLE, repeat counter=0, prev_valid=0.
- Reset during HOLD or REPEAT aborts immediately with no pending move.

Event decode:
- press = key_event[10]=1 and prev_valid=0 and [8]=0 and [9]=0.
- release = key_event[10]=0, or key_event[10]=1 with [8]=1.
- Events with [9]=1 are ignored.
- prev_valid is a registered copy of key_event[10].

Key map (upper and lower case both accepted):
- W/w: dy=-1
- X/x: dy=+1
- A/a: dx=-1
- D/d: dx=+1
- Q/q: (-1,-1)
- E/e: (+1,-1)
- Z/z: (-1,+1)
- C/c: (+1,+1)
- Any other code: no effect, but still passes through the release rule.

Move application (same logic for press and repeat):
- Clamp (WRAP=0): the move is atomic. If any nonzero axis would leave [0,BOARD-1], neither axis changes and blocked_pulse=1; otherwise both axes update and move_pulse=1.
- Wrap (WRAP=1): each axis is independent. 0-1 -> BOARD-1, BOARD-1+1 -> 0. move_pulse=1 always.
- Arithmetic is done in COORD_W+1 bits to detect underflow; the result is never outside the board.

Latency:
- A press detected in cycle T updates cursor and raises the pulse in cycle T+1.
- Pulses are registered and exactly one cycle wide.

FSM:
- IDLE:
  - move-key press -> apply move, latch key, counter=0, go to HOLD (or stay in IDLE if REPEAT_DELAY=0).
  - space press -> select_pulse; Esc press -> cancel_pulse; stay in IDLE.
- HOLD:
  - counter increments each cycle.
  - release -> IDLE.
  - counter reaches REPEAT_DELAY-1 -> apply latched move, counter=0, go to REPEAT.
- REPEAT:
  - counter increments.
  - release -> IDLE.
  - counter reaches REPEAT_PERIOD-1 -> apply move, counter=0, stay in REPEAT.
- New press in HOLD/REPEAT (valid went low then high between checks is impossible, since low = release): handled by IDLE on that edge.
- Select/Esc never auto-repeat.
- Release and repeat expiry in the same cycle: release wins, no move.
- Blocked repeats in clamp mode keep the FSM in REPEAT and pulse blocked_pulse each period.
- The counter is sized $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1) bits and never wraps.

Test Plan:
1. Reset with INIT_X=3, INIT_Y=4 -> cursor (3,4), all pulses 0. Assert rstn low mid-REPEAT -> cursor (3,4), no move_pulse next cycle.
2. WRAP=0, cursor (0,0), press 'q' -> cursor stays (0,0), blocked_pulse high one cycle. Press 'c' -> (1,1), move_pulse one cycle, asserted at T+1.
3. WRAP=0, cursor (7,3), press 'e' (x blocked, y legal) -> cursor stays (7,3), blocked_pulse=1. WRAP=1, same press -> (0,2).
4. REPEAT_DELAY=10, REPEAT_PERIOD=4, hold 'd' (valid=1) for 30 cycles from (0,0), BOARD_W=8:
   - Moves at cycles 1, 11, 15, 19, 23, 27 -> cursor (6,0).
   - Release at cycle 30 -> no further moves.
5. Space press -> select_pulse one cycle, cursor unchanged. Hold space 100 cycles -> no repeat. Esc -> cancel_pulse.
6. key_event with [9]=1 code 0x64 -> ignored. Break event [8]=1 during HOLD -> IDLE, no repeat. Release exactly on repeat-expiry cycle -> no move.

Source files
------------

// File: rtl/cursor_ctrl_rpt_if.sv
// Keyboard-event / cursor bus between the keyboard block, the cursor controller
// and the game logic. The slave side is the cursor controller.
interface cursor_ctrl_rpt_if #(
  parameter int COORD_W = 4
);
  logic [10:0]        key_event;
  logic [COORD_W-1:0] cursor_x;
  logic [COORD_W-1:0] cursor_y;
  logic               move_pulse;
  logic               blocked_pulse;
  logic               select_pulse;
  logic               cancel_pulse;

  modport master (
    output key_event,
    input  cursor_x, cursor_y, move_pulse, blocked_pulse, select_pulse, cancel_pulse
  );

  modport slave (
    input  key_event,
    output cursor_x, cursor_y, move_pulse, blocked_pulse, select_pulse, cancel_pulse
  );
endinterface

// File: rtl/cursor_ctrl_rpt.sv
// Board cursor controller: decodes keyboard events into cursor moves with
// clamp/wrap edges, atomic diagonals, typematic auto-repeat and select/cancel strobes.
module cursor_ctrl_rpt #(
  parameter int BOARD_W       = 8,
  parameter int BOARD_H       = 8,
  parameter int COORD_W       = 4,
  parameter int WRAP          = 0,
  parameter int INIT_X        = 0,
  parameter int INIT_Y        = 0,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic              clk,
  input  logic              rstn,
  cursor_ctrl_rpt_if.slave  bus
);

  localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] DELAY_LAST  = (REPEAT_DELAY > 0) ? CNT_W'(REPEAT_DELAY - 1) : '0;
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  localparam logic [COORD_W:0]   W_EXT = (COORD_W+1)'(BOARD_W);
  localparam logic [COORD_W:0]   H_EXT = (COORD_W+1)'(BOARD_H);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(BOARD_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(BOARD_H - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Axis deltas use 2-bit two's complement: 00 none, 01 +1, 11 -1
  localparam logic [1:0] D_NONE = 2'b00;
  localparam logic [1:0] D_POS  = 2'b01;
  localparam logic [1:0] D_NEG  = 2'b11;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               prev_valid;
  logic [1:0]         lat_dx, lat_dy;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic               move_q, blocked_q, select_q, cancel_q;

  logic               ev_valid, ev_ext, ev_brk;
  logic [7:0]         ev_code;
  logic               press, release_ev;
  logic               is_move;
  logic [1:0]         key_dx, key_dy;
  logic [1:0]         mv_dx, mv_dy;
  logic [COORD_W:0]   sum_x, sum_y;
  logic               x_out, y_out;
  logic [COORD_W-1:0] next_x, next_y;
  logic               mv_blocked;
  logic               do_move;

  assign ev_valid   = bus.key_event[10];
  assign ev_ext     = bus.key_event[9];
  assign ev_brk     = bus.key_event[8];
  assign ev_code    = bus.key_event[7:0];
  assign press      = ev_valid & ~prev_valid & ~ev_brk & ~ev_ext;
  assign release_ev = ~ev_valid | (ev_brk & ~ev_ext);

  always_comb begin
    is_move = 1'b1;
    key_dx  = D_NONE;
    key_dy  = D_NONE;
    case (ev_code)
      8'h57, 8'h77: key_dy = D_NEG;
      8'h58, 8'h78: key_dy = D_POS;
      8'h41, 8'h61: key_dx = D_NEG;
      8'h44, 8'h64: key_dx = D_POS;
      8'h51, 8'h71: begin key_dx = D_NEG; key_dy = D_NEG; end
      8'h45, 8'h65: begin key_dx = D_POS; key_dy = D_NEG; end
      8'h5A, 8'h7A: begin key_dx = D_NEG; key_dy = D_POS; end
      8'h43, 8'h63: begin key_dx = D_POS; key_dy = D_POS; end
      default:      is_move = 1'b0;
    endcase
  end

  // One extra bit on each axis makes both underflow (MSB set) and overflow visible
  always_comb begin
    mv_dx  = (state == ST_IDLE) ? key_dx : lat_dx;
    mv_dy  = (state == ST_IDLE) ? key_dy : lat_dy;
    sum_x  = {1'b0, cur_x} + {{(COORD_W-1){mv_dx[1]}}, mv_dx};
    sum_y  = {1'b0, cur_y} + {{(COORD_W-1){mv_dy[1]}}, mv_dy};
    x_out  = (mv_dx != D_NONE) && (sum_x[COORD_W] || (sum_x >= W_EXT));
    y_out  = (mv_dy != D_NONE) && (sum_y[COORD_W] || (sum_y >= H_EXT));
    next_x = sum_x[COORD_W-1:0];
    next_y = sum_y[COORD_W-1:0];
    mv_blocked = 1'b0;
    if (WRAP != 0) begin
      if (x_out) next_x = mv_dx[1] ? X_MAX : '0;
      if (y_out) next_y = mv_dy[1] ? Y_MAX : '0;
    end else if (x_out || y_out) begin
      mv_blocked = 1'b1;
      next_x     = cur_x;
      next_y     = cur_y;
    end
  end

  always_comb begin
    do_move = 1'b0;
    case (state)
      ST_IDLE:   do_move = press & is_move;
      ST_HOLD:   do_move = ~release_ev & (cnt == DELAY_LAST);
      ST_REPEAT: do_move = ~release_ev & (cnt == PERIOD_LAST);
      default:   do_move = 1'b0;
    endcase
  end

  // Release is checked before expiry so a key let go on the repeat cycle never moves
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      prev_valid <= 1'b0;
      lat_dx     <= D_NONE;
      lat_dy     <= D_NONE;
      cur_x      <= COORD_W'(INIT_X);
      cur_y      <= COORD_W'(INIT_Y);
      move_q     <= 1'b0;
      blocked_q  <= 1'b0;
      select_q   <= 1'b0;
      cancel_q   <= 1'b0;
    end else begin
      prev_valid <= ev_valid;
      move_q     <= 1'b0;
      blocked_q  <= 1'b0;
      select_q   <= 1'b0;
      cancel_q   <= 1'b0;

      if (do_move) begin
        if (mv_blocked) begin
          blocked_q <= 1'b1;
        end else begin
          cur_x  <= next_x;
          cur_y  <= next_y;
          move_q <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (press) begin
            if (is_move) begin
              lat_dx <= key_dx;
              lat_dy <= key_dy;
              cnt    <= '0;
              if (REPEAT_DELAY != 0) state <= ST_HOLD;
            end else if (ev_code == 8'h20) begin
              select_q <= 1'b1;
            end else if (ev_code == 8'h1B) begin
              cancel_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (release_ev) begin
            state <= ST_IDLE;
          end else if (cnt == DELAY_LAST) begin
            cnt   <= '0;
            state <= ST_REPEAT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (release_ev) begin
            state <= ST_IDLE;
          end else if (cnt == PERIOD_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cursor_x      = cur_x;
  assign bus.cursor_y      = cur_y;
  assign bus.move_pulse    = move_q;
  assign bus.blocked_pulse = blocked_q;
  assign bus.select_pulse  = select_q;
  assign bus.cancel_pulse  = cancel_q;

endmodule

// File: tb/tb_cursor_ctrl_rpt.sv
// Directed bench: a clamp and a wrap instance share one key stream and are
// checked against hand-computed cursor positions and strobes.
module tb_cursor_ctrl_rpt;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [10:0] key_event = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cursor_ctrl_rpt_if #(.COORD_W(4)) bus_c ();
  cursor_ctrl_rpt_if #(.COORD_W(4)) bus_w ();

  assign bus_c.key_event = key_event;
  assign bus_w.key_event = key_event;

  cursor_ctrl_rpt #(
    .BOARD_W(8), .BOARD_H(8), .COORD_W(4), .WRAP(0), .INIT_X(3), .INIT_Y(4),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut_clamp (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_c)
  );

  cursor_ctrl_rpt #(
    .BOARD_W(8), .BOARD_H(8), .COORD_W(4), .WRAP(1), .INIT_X(3), .INIT_Y(4),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut_wrap (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_w)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    repeat (n) tick();
  endtask

  task automatic key_down(input logic [7:0] code);
    key_event = {3'b100, code};
    tick();
  endtask

  task automatic key_up();
    key_event = '0;
    tick();
  endtask

  task automatic tap(input logic [7:0] code);
    key_down(code);
    key_up();
  endtask

  task automatic check_pos(input string tag, input int cx, input int cy, input int wx, input int wy);
    check_output({tag, "_clamp_x"}, 32'(bus_c.cursor_x), cx);
    check_output({tag, "_clamp_y"}, 32'(bus_c.cursor_y), cy);
    check_output({tag, "_wrap_x"},  32'(bus_w.cursor_x), wx);
    check_output({tag, "_wrap_y"},  32'(bus_w.cursor_y), wy);
  endtask

  task automatic do_reset();
    key_event = '0;
    rstn = 1'b0;
    tickn(2);
    rstn = 1'b1;
    tick();
  endtask

  task automatic count_pulses(input int n, output int moves);
    moves = 0;
    repeat (n) begin
      tick();
      moves += int'(bus_c.move_pulse) + int'(bus_c.blocked_pulse) + int'(bus_w.move_pulse);
    end
  endtask

  initial begin
    int exp_move;
    int pulses;

    // Reset state
    key_event = '0;
    rstn = 1'b0;
    tickn(2);
    check_pos("reset", 3, 4, 3, 4);
    check_output("reset_move",    32'(bus_c.move_pulse),    0);
    check_output("reset_blocked", 32'(bus_c.blocked_pulse), 0);
    check_output("reset_select",  32'(bus_c.select_pulse),  0);
    check_output("reset_cancel",  32'(bus_c.cancel_pulse),  0);
    rstn = 1'b1;
    tick();

    // Reset asserted while auto-repeating
    key_down(8'h64);
    check_output("rst_rpt_first_move", 32'(bus_c.move_pulse), 1);
    check_output("rst_rpt_first_x",    32'(bus_c.cursor_x),   4);
    tickn(10);
    check_output("rst_rpt_repeat_move", 32'(bus_c.move_pulse), 1);
    check_pos("rst_rpt_repeat", 5, 4, 5, 4);
    tick();
    rstn = 1'b0;
    tick();
    check_pos("rst_mid_repeat", 3, 4, 3, 4);
    check_output("rst_mid_repeat_move", 32'(bus_c.move_pulse), 0);
    key_event = '0;
    tick();
    check_output("rst_after_move", 32'(bus_c.move_pulse) | 32'(bus_w.move_pulse), 0);
    rstn = 1'b1;
    tick();

    // Walk to the corner, then diagonal against the clamp
    tap(8'h51); tap(8'h51); tap(8'h51); tap(8'h57);
    check_pos("corner", 0, 0, 0, 0);
    key_down(8'h71);
    check_pos("q_corner", 0, 0, 7, 7);
    check_output("q_corner_blocked", 32'(bus_c.blocked_pulse), 1);
    check_output("q_corner_nomove",  32'(bus_c.move_pulse),    0);
    check_output("q_corner_wrapmv",  32'(bus_w.move_pulse),    1);
    key_up();
    check_output("q_blocked_width", 32'(bus_c.blocked_pulse), 0);

    key_event = {3'b100, 8'h63};
    #1;
    check_output("c_latency_before", 32'(bus_c.move_pulse), 0);
    tick();
    check_pos("c_press", 1, 1, 0, 0);
    check_output("c_move_clamp", 32'(bus_c.move_pulse), 1);
    check_output("c_move_wrap",  32'(bus_w.move_pulse), 1);
    key_up();
    check_output("c_move_width", 32'(bus_c.move_pulse), 0);

    // Right edge: x blocked but y legal must still block the whole move
    tap(8'h44); tap(8'h64); tap(8'h44); tap(8'h64); tap(8'h44); tap(8'h64); tap(8'h44);
    tap(8'h78); tap(8'h58); tap(8'h78);
    check_pos("edge_setup", 7, 4, 7, 3);
    key_down(8'h45);
    check_pos("e_edge", 7, 4, 0, 2);
    check_output("e_edge_blocked", 32'(bus_c.blocked_pulse), 1);
    check_output("e_edge_wrapmv",  32'(bus_w.move_pulse),    1);
    key_up();

    // Typematic repeat from the origin
    do_reset();
    tap(8'h51); tap(8'h51); tap(8'h51); tap(8'h57);
    check_pos("rpt_origin", 0, 0, 0, 0);
    key_event = {3'b100, 8'h64};
    for (int k = 1; k <= 35; k++) begin
      tick();
      exp_move = (k == 1 || k == 11 || k == 15 || k == 19 || k == 23 || k == 27) ? 1 : 0;
      check_output($sformatf("rpt_move_clamp_c%0d", k), 32'(bus_c.move_pulse), exp_move);
      check_output($sformatf("rpt_move_wrap_c%0d", k),  32'(bus_w.move_pulse), exp_move);
      if (k == 30) key_event = '0;
    end
    check_pos("rpt_end", 6, 0, 6, 0);

    // Select and cancel never repeat and never move the cursor
    key_down(8'h20);
    check_output("select_clamp", 32'(bus_c.select_pulse), 1);
    check_output("select_wrap",  32'(bus_w.select_pulse), 1);
    check_output("select_nomove", 32'(bus_c.move_pulse), 0);
    check_pos("select", 6, 0, 6, 0);
    pulses = 0;
    repeat (100) begin
      tick();
      pulses += int'(bus_c.select_pulse) + int'(bus_c.move_pulse) + int'(bus_w.select_pulse);
    end
    check_output("select_hold_pulses", 32'(pulses), 0);
    key_up();
    key_down(8'h1B);
    check_output("cancel_clamp", 32'(bus_c.cancel_pulse), 1);
    check_output("cancel_wrap",  32'(bus_w.cancel_pulse), 1);
    key_up();
    check_output("cancel_width", 32'(bus_c.cancel_pulse), 0);

    // Extended codes are ignored
    key_event = {3'b110, 8'h64};
    tick();
    check_output("ext_nomove", 32'(bus_c.move_pulse) | 32'(bus_w.move_pulse), 0);
    check_pos("ext", 6, 0, 6, 0);
    key_event = '0;
    tick();

    // Break event during HOLD returns to IDLE without repeating
    key_down(8'h61);
    check_output("brk_first_move", 32'(bus_c.move_pulse), 1);
    tickn(3);
    key_event = {3'b101, 8'h61};
    tick();
    key_event = '0;
    count_pulses(15, pulses);
    check_output("brk_no_repeat", 32'(pulses), 0);
    check_pos("brk", 5, 0, 5, 0);

    // Release on the exact repeat-expiry cycle wins
    key_down(8'h61);
    check_pos("exp_first", 4, 0, 4, 0);
    tickn(9);
    check_output("exp_before", 32'(bus_c.move_pulse), 0);
    key_event = '0;
    tick();
    check_output("exp_release_nomove", 32'(bus_c.move_pulse) | 32'(bus_w.move_pulse), 0);
    count_pulses(15, pulses);
    check_output("exp_after", 32'(pulses), 0);
    check_pos("exp_end", 4, 0, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
